wb_cmd_initiator: RTL and testbench
===================================

Name: wb_cmd_initiator

Overview:
- Wishbone classic initiator that executes single or incrementing-burst read/write commands on behalf of a local requester.
- Counterpart to our Wishbone responder blocks: it drives cyc/stb/we/sel/adr/dat and consumes ack/dat.
- Sits between LA or firmware-driven command logic and any user-area Wishbone slave. It is also used as a bench-side and on-chip master for exercising slaves.
- Command in via valid/ready; read data and completion status out via valid/ready.

Parameters:
LEN_W, 4, width of cmd_len; a burst is cmd_len+1 beats (1..16 by default)
TIMEOUT, 255, cycles in REQ without ack before abort (used only with WBM_TIMEOUT_EN)

Ports:
wb_clk_i  in  1  single clock, all logic on rising edge
wb_rst_i  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_we  in  1  1=write, 0=read
cmd_adr  in  32  start byte address
cmd_dat  in  32  write data, reused for every beat (fill)
cmd_sel  in  4  byte selects, all beats
cmd_len  in  LEN_W  beats minus one
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_dat  out  32  read data (0 for write completion)
rsp_last  out  1  final response of the command
rsp_err  out  1  command aborted by timeout
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_we_o  out  1  Wishbone write enable
wbm_sel_o  out  4  Wishbone byte selects
wbm_adr_o  out  32  Wishbone address
wbm_dat_o  out  32  Wishbone write data
wbm_ack_i  in  1  Wishbone acknowledge
wbm_dat_i  in  32  Wishbone read data
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE. All outputs are 0 except cmd_ready=1. Internal address, count and data registers are cleared.
- State IDLE:
  - cmd_ready=1.
  - On accept, latch we/adr/dat/sel and remaining=cmd_len, then go to REQ.
  - cyc/stb rise on the cycle after accept (1-cycle command-to-bus latency).
- State REQ:
  - cyc=stb=1; we/sel/adr/dat are driven from the latched registers.
  - On ack, capture wbm_dat_i into rsp_dat (reads) and drop stb at that edge.
  - Read → RESP.
  - Write with remaining!=0 → GAP.
  - Write with remaining==0 → RESP.
- State GAP:
  - One cycle with cyc=1, stb=0.
  - adr += 4 (mod 2^32, wraps from 0xFFFFFFFC to 0x00000000); remaining -= 1.
  - Return to REQ. Every beat therefore sees a fresh stb rising edge.
- State RESP:
  - rsp_valid=1; rsp_last=(remaining==0); cyc stays 1 while rsp_valid waits.
  - Write completion: exactly one response, with rsp_dat=0 and rsp_last=1.
  - Read: one response per beat.
  - On rsp_ready:
    - if remaining!=0: adr += 4, remaining -= 1, go to REQ;
    - otherwise drop cyc and go to IDLE.
  - rsp_* is held stable until consumed.
- Invariants:
  - stb=1 implies cyc=1.
  - cmd_ready=0 in every non-IDLE state.
  - Back-to-back commands: with rsp_ready=1, cmd_ready is high on the cycle after the last response handshake.
- An ack seen while stb=0 is ignored.
- Reset mid-operation: cyc/stb are 0 after the reset edge, any pending response is discarded, and the block returns to IDLE.

Optional Feature:
- Macro: WBM_TIMEOUT_EN.
- When defined:
  - A counter increments every cycle in REQ and clears on entry to REQ.
  - Reaching TIMEOUT without ack drops cyc/stb and enters RESP with rsp_err=1, rsp_last=1, rsp_dat=0.
  - Remaining beats are abandoned.
- When undefined:
  - No counter exists; REQ waits indefinitely.
  - rsp_err is tied to 0.

Test Plan:
- Single read: cmd adr=0x30000000, len=0, slave acks after 1 cycle with 0x0000002A → one response: rsp_dat=0x2A, last=1, err=0; cyc low after the handshake.
- Write burst: we=1, adr=0x30000010, dat=0xDEADBEEF, sel=0xF, len=2 → three acked beats at 0x10/0x14/0x18, stb low for one cycle between beats, one response with rsp_dat=0 and last=1.
- Read burst with backpressure: len=3, rsp_ready held low 5 cycles per beat → four responses in address order with last only on the 4th; no stb while rsp_valid is pending; rsp_dat stable while stalled.
- Address wrap: read adr=0xFFFFFFFC, len=1 → beats at 0xFFFFFFFC, then 0x00000000.
- Reset mid-burst: assert wb_rst_i during the 2nd beat of a len=3 read → cyc=stb=rsp_valid=0 and cmd_ready=1 after the edge; a following command executes normally.
- WBM_TIMEOUT_EN, TIMEOUT=8: slave never acks → stb high exactly 8 cycles, then a response with err=1, last=1; cmd_ready returns high after the handshake.

Source files
------------

// File: rtl/wb_cmd_initiator.sv
// wb_cmd_initiator: Wishbone classic initiator for single and incrementing-burst
// read/write commands. Command in via valid/ready, responses out via valid/ready.
// Every beat gets its own stb rising edge. Write bursts issue one completion
// response. Read bursts issue one response per beat.
// Optional feature macro: WBM_TIMEOUT_EN aborts a beat left unacked for TIMEOUT cycles.
module wb_cmd_initiator #(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [31:0]      cmd_adr,
  input  logic [31:0]      cmd_dat,
  input  logic [3:0]       cmd_sel,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_dat,
  output logic             rsp_last,
  output logic             rsp_err,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [31:0]      wbm_dat_i,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_RESP} state_e;

  state_e            state_q;
  logic              we_q, cyc_q, err_q;
  logic [31:0]       adr_q, dat_q, rdat_q;
  logic [3:0]        sel_q;
  logic [LEN_W-1:0]  rem_q;

  logic [31:0]       adr_d;
  logic [LEN_W-1:0]  rem_d;
  logic              last_beat;
  logic              tmo_hit;

  // Address wraps naturally modulo 2^32.
  assign adr_d     = adr_q + 32'd4;
  assign rem_d     = rem_q - LEN_W'(1);
  assign last_beat = (rem_q == '0);

`ifdef WBM_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] tmo_q;
  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

  // Count cycles spent in REQ. The count is zero whenever REQ is entered.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || state_q != S_REQ) tmo_q <= '0;
    else                              tmo_q <= tmo_q + TW'(1);
  end

  assign rsp_err = (state_q == S_RESP) && err_q;
`else
  localparam int unused_timeout = TIMEOUT;
  logic unused_err;
  assign unused_err = err_q;
  assign tmo_hit    = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  // Command FSM. All bus and response state is held in registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      err_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdat_q  <= '0;
      sel_q   <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (cmd_valid) begin
          we_q    <= cmd_we;
          adr_q   <= cmd_adr;
          dat_q   <= cmd_dat;
          sel_q   <= cmd_sel;
          rem_q   <= cmd_len;
          rdat_q  <= '0;
          err_q   <= 1'b0;
          cyc_q   <= 1'b1;
          state_q <= S_REQ;
        end
        S_REQ: if (wbm_ack_i) begin
          if (!we_q) rdat_q <= wbm_dat_i;
          // Write bursts only report once, after their final beat.
          state_q <= (!we_q || last_beat) ? S_RESP : S_GAP;
        end else if (tmo_hit) begin
          // Abandon the remaining beats. Setting rem to zero makes this the last response.
          cyc_q   <= 1'b0;
          err_q   <= 1'b1;
          rem_q   <= '0;
          rdat_q  <= '0;
          state_q <= S_RESP;
        end
        S_GAP: begin
          adr_q   <= adr_d;
          rem_q   <= rem_d;
          state_q <= S_REQ;
        end
        S_RESP: if (rsp_ready) begin
          if (!last_beat) begin
            adr_q   <= adr_d;
            rem_q   <= rem_d;
            state_q <= S_REQ;
          end else begin
            cyc_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_last  = (state_q == S_RESP) && last_beat;
  assign rsp_dat   = rdat_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = (state_q == S_REQ);
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed bench for wb_cmd_initiator. A registered Wishbone slave model acks
// one cycle after stb, returns adr ^ KEY and logs every acked beat.
module tb_wb_cmd_initiator;

  localparam logic [31:0] KEY = 32'h3000_002A;

  logic        clk = 1'b0, rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel, cmd_len;
  logic        rsp_valid, rsp_ready, rsp_last, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we, ack, busy;
  logic [3:0]  sel;
  logic [31:0] adr, wdat, rdat;

  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  wb_cmd_initiator #(.LEN_W(4), .TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_last(rsp_last), .rsp_err(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_ack_i(ack), .wbm_dat_i(rdat),
    .busy(busy)
  );

  // slave model and beat log
  logic        slave_en;
  logic [31:0] b_adr[$], b_dat[$];
  logic        b_we[$];
  logic [3:0]  b_sel[$];

  always @(posedge clk) begin
    if (rst) ack <= 1'b0;
    else if (ack) ack <= 1'b0;
    else if (cyc && stb && slave_en) begin
      ack  <= 1'b1;
      rdat <= adr ^ KEY;
      b_adr.push_back(adr); b_dat.push_back(wdat);
      b_we.push_back(we);   b_sel.push_back(sel);
    end
  end

  // protocol monitor
  int viol, stb_cyc, stb_rise, gap_run, gap_max, err_seen;
  logic stb_prev = 1'b0;
  always @(negedge clk) begin
    if (stb && !cyc) viol++;
    if (stb && rsp_valid) viol++;
    if (rsp_err) err_seen++;
    if (stb) stb_cyc++;
    if (stb && !stb_prev) stb_rise++;
    stb_prev = stb;
    if (cyc && !stb && !rsp_valid) gap_run++;
    else begin
      if (gap_run > gap_max) gap_max = gap_run;
      gap_run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    viol = 0; stb_cyc = 0; stb_rise = 0; gap_run = 0; gap_max = 0;
    b_adr.delete(); b_dat.delete(); b_we.delete(); b_sel.delete();
  endtask

  // called at a negedge, returns at the negedge after acceptance
  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [3:0] l);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s; cmd_len = l; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("cmd_lat_cyc", cyc, 1);
    chk("cmd_lat_stb", stb, 1);
    chk("cmd_ready_busy", cmd_ready, 0);
  endtask

  task automatic get_rsp(input int stall, output logic [31:0] d, output logic l, output logic e);
    int t = 0;
    while (!rsp_valid && t < 200) begin @(negedge clk); t++; end
    d = rsp_dat; l = rsp_last; e = rsp_err;
    if (!rsp_valid) begin
      chk("rsp_wait_expired", 0, 1);
      return;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("rsp_dat_hold", rsp_dat, d);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  logic [31:0] d;
  logic        l, e;
  logic [31:0] exp_rd [4] = '{32'h0000_012A, 32'h0000_012E, 32'h0000_0122, 32'h0000_0126};

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    cmd_sel = '0; cmd_len = '0; rsp_ready = 1'b0; slave_en = 1'b1; err_seen = 0;
    rdat = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_cyc", cyc, 0);
    chk("rst_stb", stb, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_last", rsp_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_adr", adr, 0);
    rst = 1'b0;
    @(negedge clk);

    // single read
    clr_mon();
    send_cmd(1'b0, 32'h3000_0000, 32'h0, 4'hF, 4'd0);
    get_rsp(0, d, l, e);
    chk("rd1_dat", d, 32'h2A);
    chk("rd1_last", l, 1);
    chk("rd1_err", e, 0);
    chk("rd1_cyc_after", cyc, 0);
    chk("rd1_cmd_ready_after", cmd_ready, 1);
    chk("rd1_beats", b_adr.size(), 1);

    // write burst, 3 beats
    clr_mon();
    send_cmd(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 4'd2);
    get_rsp(0, d, l, e);
    chk("wr_dat", d, 0);
    chk("wr_last", l, 1);
    chk("wr_beats", b_adr.size(), 3);
    if (b_adr.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("wr_adr", b_adr[i], 32'h3000_0010 + 32'(4 * i));
        chk("wr_wdat", b_dat[i], 32'hDEAD_BEEF);
        chk("wr_we", b_we[i], 1);
        chk("wr_sel", b_sel[i], 4'hF);
      end
    end
    chk("wr_stb_rises", stb_rise, 3);
    chk("wr_gap_len", gap_max, 1);
    chk("wr_cmd_ready_after", cmd_ready, 1);

    // read burst with backpressure
    clr_mon();
    send_cmd(1'b0, 32'h3000_0100, 32'h0, 4'h3, 4'd3);
    for (int i = 0; i < 4; i++) begin
      get_rsp(5, d, l, e);
      chk("rdb_dat", d, exp_rd[i]);
      chk("rdb_last", l, (i == 3) ? 1 : 0);
    end
    chk("rdb_beats", b_adr.size(), 4);
    chk("rdb_viol", viol, 0);
    chk("rdb_cyc_after", cyc, 0);

    // address wrap
    clr_mon();
    send_cmd(1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 4'd1);
    get_rsp(0, d, l, e);
    chk("wrap_dat0", d, 32'hCFFF_FFD6);
    chk("wrap_last0", l, 0);
    get_rsp(0, d, l, e);
    chk("wrap_dat1", d, 32'h3000_002A);
    chk("wrap_last1", l, 1);
    chk("wrap_beats", b_adr.size(), 2);
    if (b_adr.size() == 2) begin
      chk("wrap_adr0", b_adr[0], 32'hFFFF_FFFC);
      chk("wrap_adr1", b_adr[1], 32'h0000_0000);
    end

    // reset during the second beat
    clr_mon();
    send_cmd(1'b0, 32'h3000_0200, 32'h0, 4'hF, 4'd3);
    get_rsp(0, d, l, e);
    chk("mrst_dat0", d, 32'h0000_022A);
    chk("mrst_stb_beat2", stb, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_cyc", cyc, 0);
    chk("mrst_stb", stb, 0);
    chk("mrst_rsp_valid", rsp_valid, 0);
    chk("mrst_cmd_ready", cmd_ready, 1);
    rst = 1'b0;
    @(negedge clk);
    clr_mon();
    send_cmd(1'b1, 32'h3000_0040, 32'h1234_5678, 4'h3, 4'd0);
    get_rsp(0, d, l, e);
    chk("post_dat", d, 0);
    chk("post_last", l, 1);
    chk("post_beats", b_adr.size(), 1);
    if (b_adr.size() == 1) begin
      chk("post_adr", b_adr[0], 32'h3000_0040);
      chk("post_wdat", b_dat[0], 32'h1234_5678);
      chk("post_sel", b_sel[0], 4'h3);
    end

`ifdef WBM_TIMEOUT_EN
    // slave never acks
    clr_mon();
    slave_en = 1'b0;
    send_cmd(1'b0, 32'h3000_0300, 32'h0, 4'hF, 4'd2);
    get_rsp(0, d, l, e);
    chk("tmo_stb_cycles", stb_cyc, 8);
    chk("tmo_err", e, 1);
    chk("tmo_last", l, 1);
    chk("tmo_dat", d, 0);
    chk("tmo_cmd_ready", cmd_ready, 1);
    chk("tmo_cyc", cyc, 0);
    slave_en = 1'b1;
`else
    chk("no_err_seen", err_seen, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
